// File: rtl/sync_loadable_modn_down_counter.sv
// Synchronous, loadable modulo-MOD down counter with wrap and one-shot modes.
// Counts MOD-1 down to 0. tc is a combinational borrow for cascading stages.
// Optional macro MODN_DN_UFL_CNT_EN adds a saturating 8-bit wrap-event counter
// on ufl_cnt; without it ufl_cnt is tied to zero.
module sync_loadable_modn_down_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] data,
    input  logic             cnt_en,
    input  logic             borrow_in,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             done,
    output logic [7:0]       ufl_cnt
);

    localparam logic [WIDTH-1:0] MAXQ    = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             cnt;
    logic             q_zero;

    // Out-of-range load values clamp to the top of the count range so q < MOD always holds.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
        if ({1'b0, d} < MOD_EXT)
            return d;
        else
            return MAXQ;
    endfunction

    assign cnt    = cnt_en & borrow_in;
    assign q_zero = (q == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic: load enters RUN from anywhere; one-shot expiry moves RUN to DONE.
    always_comb begin
        state_nxt = state;
        if (load_en) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_RUN:   if (cnt && q_zero && oneshot) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs: tc is a same-cycle borrow; done reflects the registered DONE state.
    always_comb begin
        tc   = (state == S_RUN) && q_zero && cnt;
        done = (state == S_DONE);
    end

    // Next count value: load beats count; only RUN decrements, wrapping or sticking at zero.
    always_comb begin
        q_nxt = q;
        if (load_en) begin
            q_nxt = clamp_load(data);
        end else if ((state == S_RUN) && cnt) begin
            if (!q_zero)
                q_nxt = q - 1'b1;
            else if (!oneshot)
                q_nxt = MAXQ;
            else
                q_nxt = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else
            q <= q_nxt;
    end

`ifdef MODN_DN_UFL_CNT_EN
    logic wrap;
    assign wrap = (state == S_RUN) && q_zero && cnt && !oneshot;

    // Saturating wrap-event counter; a load clears it even when a wrap coincides.
    always_ff @(posedge clk) begin
        if (rst || load_en)
            ufl_cnt <= 8'd0;
        else if (wrap && (ufl_cnt != 8'hFF))
            ufl_cnt <= ufl_cnt + 8'd1;
    end
`else
    assign ufl_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sync_loadable_modn_down_counter.sv
// Self-checking bench for sync_loadable_modn_down_counter (WIDTH=4, MOD=12).
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model that tracks the count as a plain integer.
module tb_sync_loadable_modn_down_counter;

    localparam int WIDTH = 4;
    localparam int MOD   = 12;
`ifdef MODN_DN_UFL_CNT_EN
    localparam bit UFL_ON = 1'b1;
`else
    localparam bit UFL_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_en = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic             cnt_en = 1'b0;
    logic             borrow_in = 1'b1;
    logic             oneshot = 1'b0;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             done;
    logic [7:0]       ufl_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: integer count, phase (0 idle, 1 running, 2 expired), wrap tally.
    int m_q   = 0;
    int m_ph  = 0;
    int m_ufl = 0;
    int tc_seen;

    always #5 clk = ~clk;

    sync_loadable_modn_down_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .data(data),
        .cnt_en(cnt_en), .borrow_in(borrow_in), .oneshot(oneshot),
        .q(q), .tc(tc), .done(done), .ufl_cnt(ufl_cnt)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check tc before the edge, advance model, check registers.
    task automatic cyc(input bit r, input bit l, input int d, input bit ce, input bit bi, input bit os);
        int exp_tc;
        @(negedge clk);
        rst = r; load_en = l; data = d[WIDTH-1:0]; cnt_en = ce; borrow_in = bi; oneshot = os;
        #1;
        exp_tc = (m_ph == 1 && m_q == 0 && ce && bi) ? 1 : 0;
        check("tc", int'(tc), exp_tc);
        tc_seen += exp_tc;
        @(posedge clk);
        if (r) begin
            m_q = 0; m_ph = 0; m_ufl = 0;
        end else if (l) begin
            m_q = (d < MOD) ? d : MOD - 1;
            m_ph = 1; m_ufl = 0;
        end else if (m_ph == 1 && ce && bi) begin
            if (m_q > 0) m_q = m_q - 1;
            else if (!os) begin
                m_q = MOD - 1;
                m_ufl = (m_ufl < 255) ? m_ufl + 1 : 255;
            end else m_ph = 2;
        end
        #1;
        check("q", int'(q), m_q);
        check("done", int'(done), (m_ph == 2) ? 1 : 0);
        check("ufl_cnt", int'(ufl_cnt), UFL_ON ? m_ufl : 0);
    endtask

    initial begin
        int seq5 [8] = '{4, 3, 2, 1, 0, 11, 10, 9};
        bit os_r = 1'b0;
        tc_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", int'(q), 0);
        check("reset_done", int'(done), 0);

        // Idle holds after reset even with counting enabled.
        cyc(1, 0, 0, 0, 1, 0);
        repeat (5) cyc(0, 0, 0, 1, 1, 0);
        check("idle_q", int'(q), 0);

        // Wrap-mode sequence from 5.
        cyc(0, 1, 5, 1, 1, 0);
        check("load5", int'(q), 5);
        tc_seen = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, 1, 0);
            check("wrap_seq", int'(q), seq5[i]);
        end
        check("wrap_tc_count", tc_seen, 1);

        // Clamped loads.
        cyc(0, 1, 13, 0, 1, 0); check("clamp13", int'(q), 11);
        cyc(0, 1, 15, 0, 1, 0); check("clamp15", int'(q), 11);
        cyc(0, 1, 11, 0, 1, 0); check("load11", int'(q), 11);

        // One-shot expiry and reload.
        cyc(0, 1, 2, 1, 1, 1);
        tc_seen = 0;
        repeat (5) cyc(0, 0, 0, 1, 1, 1);
        check("os_q", int'(q), 0);
        check("os_done", int'(done), 1);
        check("os_tc_count", tc_seen, 1);
        cyc(0, 1, 7, 1, 1, 1);
        check("reload_done", int'(done), 0);
        check("reload_q", int'(q), 7);

        // Priority: load over count, borrow gating, reset over load.
        cyc(0, 1, 3, 0, 1, 0);
        cyc(0, 1, 9, 1, 1, 0);  check("load_wins", int'(q), 9);
        cyc(0, 0, 0, 1, 0, 0);  check("borrow_hold", int'(q), 9);
        cyc(0, 1, 6, 0, 1, 0);
        cyc(1, 1, 6, 1, 1, 0);  check("rst_wins", int'(q), 0);
        repeat (3) cyc(0, 0, 0, 1, 1, 0);
        check("rst_idle", int'(q), 0);

        // Load 0 in one-shot mode: tc on first count, DONE after.
        cyc(0, 1, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1, 1);  check("os0_done", int'(done), 1);

        // Wrap tally: load 0 then 25 counts gives 3 wraps.
        cyc(0, 1, 0, 0, 1, 0);
        repeat (25) cyc(0, 0, 0, 1, 1, 0);
        check("ufl3", int'(ufl_cnt), UFL_ON ? 3 : 0);
        cyc(0, 1, 4, 1, 1, 0);
        check("ufl_clear", int'(ufl_cnt), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) os_r = ~os_r;
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, os_r);
        end

        // Long wrap run to reach saturation of the wrap tally.
        cyc(0, 1, 0, 0, 1, 0);
        repeat (3100) cyc(0, 0, 0, 1, 1, 0);
        check("ufl_sat", int'(ufl_cnt), UFL_ON ? 255 : 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
